pipe_stage_buf: RTL

Parametrised elastic buffer placed between two pipeline stages. It is the generalised successor of the fixed single-register stage hand-off (if_out_t to id_out_t and onward).
- Carries an opaque WIDTH-bit stage payload through a DEPTH-entry FIFO.
- Upstream bubbles become in_valid=0; downstream stall becomes out_ready=0.
- A flush kills all buffered entries.
- Lets a stage absorb downstream stalls without a combinational stall path back to the producer.

---
 rtl/pipe_stage_buf_pkg.sv | 36 +++
 rtl/pipe_stage_buf_if.sv | 21 ++
 rtl/pipe_stage_buf_mem.sv | 36 +++
 rtl/pipe_stage_buf.sv | 104 ++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared types and helpers for the elastic pipeline stage buffer
package pipe_stage_buf_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Stage outputs travel through the buffer as flat bit vectors of the same size.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_out_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
    } id_out_t;

    localparam int IF_OUT_W = $bits(if_out_t);
    localparam int ID_OUT_W = $bits(id_out_t);

    typedef logic [IF_OUT_W-1:0] if_out_bits_t;
    typedef logic [ID_OUT_W-1:0] id_out_bits_t;

    typedef struct packed {
        logic [31:0] stall;
        logic [31:0] bubble;
        logic [31:0] full;
    } perf_cnt_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - upstream/downstream handshake bundle around the stage buffer
interface pipe_stage_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_buf_mem.sv
// rtl/pipe_stage_buf_mem.sv - DEPTH x WIDTH register array, one write port, one registered read port
module pipe_stage_buf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    input  logic             clr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-through covers the entry that becomes head on the same edge it is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (we && (waddr == raddr)) begin
            rd_data <= wdata;
        end else begin
            rd_data <= mem[raddr];
        end
    end
endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic FIFO between pipeline stages; PIPE_STAGE_BUF_PERF_EN adds perf counters
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    pipe_stage_buf_if.slave   bus,
    output logic [CNT_W-1:0]  count
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles,
    output logic [31:0]       full_cycles
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             push, pop;

    // Ready and valid come only from the registered count, so no stall path crosses the stage.
    assign bus.in_ready  = (count != CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);

    assign push = bus.in_valid  & bus.in_ready  & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (flush) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // The read port is addressed with the next head so out_data is ready the cycle after.
    pipe_stage_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (push),
        .waddr   (wr_ptr),
        .wdata   (bus.in_data),
        .raddr   (rd_ptr_nxt),
        .clr     (flush),
        .rd_data (bus.out_data)
    );

`ifdef PIPE_STAGE_BUF_PERF_EN
    perf_cnt_t perf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && !flush) begin
                perf.stall <= sat_inc(perf.stall);
            end
            if (!bus.out_valid) begin
                perf.bubble <= sat_inc(perf.bubble);
            end
            if (count == CNT_W'(DEPTH)) begin
                perf.full <= sat_inc(perf.full);
            end
        end
    end

    assign stall_cycles  = perf.stall;
    assign bubble_cycles = perf.bubble;
    assign full_cycles   = perf.full;
`endif
endmodule
